// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - shared main-memory sequencer for I/D cache block fills and D write-through stores
`timescale 1ns/1ps
module mem_fill_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int WORDS   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss,
    input  logic [15:0]              i_miss_addr,
    input  logic                     d_miss,
    input  logic [15:0]              d_miss_addr,
    input  logic                     d_wr_req,
    input  logic [15:0]              d_wr_addr,
    input  logic [15:0]              d_wr_data,
    input  logic [15:0]              mem_data_in,
    input  logic                     mem_data_valid,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [15:0]              mem_addr,
    output logic [15:0]              mem_data_out,
    output logic [15:0]              fill_data,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     i_fill_we,
    output logic                     d_fill_we,
    output logic                     i_tag_we,
    output logic                     d_tag_we,
    output logic                     d_wr_ack,
    output logic                     arb_busy
);

    localparam int WIDX_W = $clog2(WORDS);
    localparam int AGE_W  = $clog2(MEM_LAT + 1);

    localparam logic [WIDX_W:0]   ISSUE_END = (WIDX_W + 1)'(WORDS);
    localparam logic [WIDX_W:0]   ISSUE_ONE = (WIDX_W + 1)'(1);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);
    localparam logic [WIDX_W-1:0] WORD_ONE  = WIDX_W'(1);
    localparam logic [AGE_W-1:0]  AGE_READY = AGE_W'(MEM_LAT);
    localparam logic [AGE_W-1:0]  AGE_ONE   = AGE_W'(1);
    localparam logic [15:0]       BLK_MASK  = ~16'(2 * WORDS - 1);

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_grant_d;
    logic [15:0]         r_base;
    logic [WIDX_W:0]     r_issue_cnt;
    logic [WIDX_W-1:0]   r_recv_cnt;
    logic [AGE_W-1:0]    r_age;

    logic                w_start;
    logic                w_grant_d_nxt;
    logic [15:0]         w_base_nxt;
    logic                w_issue;
    logic                w_recv;
    logic                w_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_grant_d_nxt = r_grant_d;
        w_base_nxt    = r_base;
        w_issue       = 1'b0;
        w_recv        = 1'b0;
        w_last        = 1'b0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = 16'h0000;
        mem_data_out  = 16'h0000;
        fill_data     = 16'h0000;
        fill_word     = '0;
        i_fill_we     = 1'b0;
        d_fill_we     = 1'b0;
        i_tag_we      = 1'b0;
        d_tag_we      = 1'b0;
        d_wr_ack      = 1'b0;
        arb_busy      = 1'b0;

        if (!rst) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (d_miss) begin
                        w_start       = 1'b1;
                        w_grant_d_nxt = 1'b1;
                        w_base_nxt    = d_miss_addr & BLK_MASK;
                    end else if (d_wr_req) begin
                        mem_en       = 1'b1;
                        mem_wr       = 1'b1;
                        mem_addr     = d_wr_addr;
                        mem_data_out = d_wr_data;
                        d_wr_ack     = 1'b1;
                    end else if (i_miss) begin
                        w_start       = 1'b1;
                        w_grant_d_nxt = 1'b0;
                        w_base_nxt    = i_miss_addr & BLK_MASK;
                    end
                end
                ST_FILL: begin
                    arb_busy = 1'b1;
                    w_issue  = (r_issue_cnt < ISSUE_END);
                    if (w_issue) begin
                        mem_en   = 1'b1;
                        mem_addr = r_base + 16'({r_issue_cnt[WIDX_W-1:0], 1'b0});
                    end
                    // No read of this fill can return before MEM_LAT cycles in, so earlier valids are stale.
                    w_recv = mem_data_valid && (r_age == AGE_READY);
                    if (w_recv) begin
                        fill_data = mem_data_in;
                        fill_word = r_recv_cnt;
                        i_fill_we = !r_grant_d;
                        d_fill_we = r_grant_d;
                        w_last    = (r_recv_cnt == LAST_WORD);
                        i_tag_we  = w_last && !r_grant_d;
                        d_tag_we  = w_last && r_grant_d;
                    end
                end
                default: ;
            endcase
            if (w_start) w_state_nxt = ST_FILL;
            if (w_last)  w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant_d   <= 1'b0;
            r_base      <= 16'h0000;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_age       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant_d <= w_grant_d_nxt;
            r_base    <= w_base_nxt;
            if (r_state == ST_IDLE || w_last) begin
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
                r_age       <= '0;
            end else begin
                if (w_issue)               r_issue_cnt <= r_issue_cnt + ISSUE_ONE;
                if (w_recv)                r_recv_cnt  <= r_recv_cnt + WORD_ONE;
                if (r_age != AGE_READY)    r_age       <= r_age + AGE_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - scoreboard bench for mem_fill_arbiter with a timestamped transaction model
`timescale 1ns/1ps
module tb_mem_fill_arbiter;

    localparam int MEM_LAT  = 4;
    localparam int WORDS    = 8;
    localparam int FILL_LEN = WORDS - 1 + MEM_LAT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req, mem_data_valid;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_data_in;
    logic        mem_en, mem_wr, i_fill_we, d_fill_we, i_tag_we, d_tag_we, d_wr_ack, arb_busy;
    logic [15:0] mem_addr, mem_data_out, fill_data;
    logic [2:0]  fill_word;
    logic [58:0] all_out;

    assign all_out = {mem_en, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
                      i_fill_we, d_fill_we, i_tag_we, d_tag_we, d_wr_ack, arb_busy};

    mem_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
        .d_wr_ack(d_wr_ack), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [15:0] addr; } rd_t;
    typedef struct { int cyc; bit side; int word; logic [15:0] data; } fl_t;
    typedef struct { int cyc; bit side; } tg_t;
    typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } wr_t;

    rd_t rd_q[$];
    fl_t fl_q[$];
    tg_t tg_q[$];
    wr_t wr_q[$];

    int  n_chk = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  g_cyc = -1000;
    bit  exp_busy = 1'b0;
    bit  d_out, i_out, wr_acc, keep_store;
    int  d_tag = -1;
    int  i_tag = -1;

    bit          pv[MEM_LAT];
    logic [15:0] pa[MEM_LAT];

    function automatic logic [15:0] memval(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check_ok(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        check_ok(nm, act == exp, act, exp);
    endtask

    function automatic bit model_idle();
        return !(cyc > g_cyc && cyc <= g_cyc + FILL_LEN);
    endfunction

    // A grant at cycle g: reads on g+1.., words back MEM_LAT later, tag with the last word.
    task automatic start_fill(input bit side, input logic [15:0] addr);
        logic [15:0] base;
        base  = addr & 16'hFFF0;
        g_cyc = cyc;
        for (int k = 0; k < WORDS; k++) begin
            rd_q.push_back('{cyc + 1 + k, base + 16'(2 * k)});
            fl_q.push_back('{cyc + 1 + MEM_LAT + k, side, k, memval(base + 16'(2 * k))});
        end
        tg_q.push_back('{cyc + FILL_LEN, side});
        if (side) d_tag = cyc + FILL_LEN;
        else      i_tag = cyc + FILL_LEN;
    endtask

    task automatic run_model();
        bit idle;
        idle = model_idle();
        if (rst) begin
            rd_q.delete(); fl_q.delete(); tg_q.delete(); wr_q.delete();
            g_cyc = -1000; d_tag = -1; i_tag = -1;
            exp_busy = 1'b0;
        end else begin
            exp_busy = !idle;
            if (idle) begin
                if (d_miss) start_fill(1'b1, d_miss_addr);
                else if (d_wr_req) begin
                    wr_q.push_back('{cyc, d_wr_addr, d_wr_data});
                    wr_acc = 1'b1;
                end else if (i_miss) start_fill(1'b0, i_miss_addr);
            end
        end
    endtask

    task automatic next_cycle();
        bit          iss;
        logic [15:0] iss_a;
        @(negedge clk);
        iss   = mem_en && !mem_wr;
        iss_a = mem_addr;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = MEM_LAT - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pa[k] = pa[k-1];
        end
        pv[0] = iss;
        pa[0] = iss_a;
        mem_data_valid = pv[MEM_LAT-1];
        mem_data_in    = pv[MEM_LAT-1] ? memval(pa[MEM_LAT-1]) : 16'h0000;
    endtask

    task automatic tick();
        run_model();
        next_cycle();
        if (d_tag >= 0 && cyc > d_tag) begin d_miss = 1'b0; d_out = 1'b0; d_tag = -1; end
        if (i_tag >= 0 && cyc > i_tag) begin i_miss = 1'b0; i_out = 1'b0; i_tag = -1; end
        if (wr_acc) begin
            wr_acc = 1'b0;
            if (!keep_store) d_wr_req = 1'b0;
        end
    endtask

    task automatic wait_quiet();
        int budget;
        budget = 100;
        while ((d_out || i_out || d_wr_req) && budget > 0) begin
            tick();
            budget--;
        end
        check_ok("quiet_timeout", budget > 0, 64'(budget), 64'd1);
        tick();
    endtask

    always @(negedge clk) begin
        rd_t r; fl_t f; tg_t t; wr_t w;
        if (rst) check_eq("reset_outputs_zero", 64'(all_out), 64'd0);
        check_eq("arb_busy", 64'(arb_busy), 64'(exp_busy));
        if (mem_en && !mem_wr) begin
            if (rd_q.size() == 0) check_ok("read_unexpected", 1'b0, {16'(cyc), mem_addr}, 64'd0);
            else begin
                r = rd_q.pop_front();
                check_eq("read", {16'(cyc), mem_addr}, {16'(r.cyc), r.addr});
            end
        end
        if (mem_en && mem_wr) begin
            if (wr_q.size() == 0) check_ok("write_unexpected", 1'b0, {16'(cyc), mem_addr}, 64'd0);
            else begin
                w = wr_q.pop_front();
                check_eq("write", {16'(cyc), mem_addr, mem_data_out, 8'(d_wr_ack)},
                                  {16'(w.cyc), w.addr, w.data, 8'd1});
            end
        end
        if (d_wr_ack && !(mem_en && mem_wr)) check_ok("ack_without_write", 1'b0, 64'(d_wr_ack), 64'd0);
        if (i_fill_we && d_fill_we) check_ok("fill_we_both", 1'b0, 64'd3, 64'd1);
        if (i_fill_we || d_fill_we) begin
            if (fl_q.size() == 0) check_ok("fill_unexpected", 1'b0, {16'(cyc), fill_data}, 64'd0);
            else begin
                f = fl_q.pop_front();
                check_eq("fill", {16'(cyc), 8'(d_fill_we), 8'(fill_word), fill_data},
                                 {16'(f.cyc), 8'(f.side), 8'(f.word), f.data});
            end
        end
        if (i_tag_we || d_tag_we) begin
            if (tg_q.size() == 0) check_ok("tag_unexpected", 1'b0, {16'(cyc), 8'(d_tag_we)}, 64'd0);
            else begin
                t = tg_q.pop_front();
                check_eq("tag", {16'(cyc), 8'(d_tag_we), 8'(i_tag_we)},
                                {16'(t.cyc), 8'(t.side), 8'(!t.side)});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0; mem_data_valid = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0; mem_data_in = 16'h0;
        d_out = 1'b0; i_out = 1'b0; wr_acc = 1'b0; keep_store = 1'b0;
        for (int k = 0; k < MEM_LAT; k++) begin pv[k] = 1'b0; pa[k] = 16'h0; end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single D fill of the block holding 0x1236
        d_miss = 1'b1; d_miss_addr = 16'h1236; d_out = 1'b1;
        wait_quiet();

        // simultaneous misses: D first, one IDLE cycle, then I
        d_miss = 1'b1; d_miss_addr = 16'h2000; d_out = 1'b1;
        i_miss = 1'b1; i_miss_addr = 16'h0040; i_out = 1'b1;
        wait_quiet();

        // store in IDLE
        d_wr_req = 1'b1; d_wr_addr = 16'h3002; d_wr_data = 16'hBEEF;
        wait_quiet();

        // store raised during an I fill waits for the following IDLE cycle
        i_miss = 1'b1; i_miss_addr = 16'h0102; i_out = 1'b1;
        repeat (4) tick();
        d_wr_req = 1'b1; d_wr_addr = 16'h5554; d_wr_data = 16'h1234;
        wait_quiet();

        // reset at FILL cycle 6, stale returns afterwards must be ignored
        d_miss = 1'b1; d_miss_addr = 16'h4A10; d_out = 1'b1;
        repeat (7) tick();
        rst = 1'b1; d_miss = 1'b0; d_out = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // I miss dropped at FILL cycle 2 still completes and tags
        i_miss = 1'b1; i_miss_addr = 16'h7778; i_out = 1'b1;
        repeat (3) tick();
        i_miss = 1'b0;
        wait_quiet();

        for (int n = 0; n < 3000; n++) begin
            keep_store = ($urandom_range(0, 1) == 0);
            if (!d_out && $urandom_range(0, 15) == 0) begin
                d_miss = 1'b1; d_miss_addr = 16'($urandom); d_out = 1'b1;
            end
            if (!i_out && $urandom_range(0, 15) == 0) begin
                i_miss = 1'b1; i_miss_addr = 16'($urandom); i_out = 1'b1;
            end
            if (!d_wr_req && $urandom_range(0, 5) == 0) begin
                d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
            if (d_tag >= 0 && cyc == d_tag - FILL_LEN + 3 && $urandom_range(0, 3) == 0) d_miss = 1'b0;
            if (i_tag >= 0 && cyc == i_tag - FILL_LEN + 3 && $urandom_range(0, 3) == 0) i_miss = 1'b0;
            if (model_idle() && !mem_data_valid && $urandom_range(0, 7) == 0) begin
                mem_data_valid = 1'b1; mem_data_in = 16'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; d_miss = 1'b0; i_miss = 1'b0; d_wr_req = 1'b0;
                d_out = 1'b0; i_out = 1'b0;
            end
            tick();
            rst = 1'b0;
        end

        keep_store = 1'b0;
        wait_quiet();
        repeat (20) tick();

        check_eq("leftover_reads", 64'(rd_q.size()), 64'd0);
        check_eq("leftover_fills", 64'(fl_q.size()), 64'd0);
        check_eq("leftover_tags", 64'(tg_q.size()), 64'd0);
        check_eq("leftover_writes", 64'(wr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
